// File: rtl/id_ctrl_seq.sv
// Registered RV32IM control decoder sitting at the ID/EX boundary.
// Holds off issue with a latency counter while the multi-cycle M unit is occupied.
module id_ctrl_seq #(
  parameter int EN_M    = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       flush,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] ALU_op,
  output logic       sel_opA,
  output logic       sel_opB,
  output logic       is_stype,
  output logic       wr_en,
  output logic [2:0] dm_select,
  output logic [2:0] imm_select,
  output logic [1:0] sel_data,
  output logic [1:0] store_select,
  output logic       is_muldiv,
  output logic [2:0] muldiv_op,
  output logic       muldiv_start,
  output logic       illegal
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy, accept;

  logic [3:0] alu_f3;
  logic [3:0] dec_alu_op;
  logic       dec_sel_opa, dec_sel_opb, dec_is_stype, dec_wr_en;
  logic [2:0] dec_dm_select, dec_imm_select, dec_muldiv_op;
  logic [1:0] dec_sel_data, dec_store_select;
  logic       dec_is_muldiv, dec_illegal;

  logic       out_valid_q, out_valid_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic       sel_opa_q, sel_opa_d, sel_opb_q, sel_opb_d;
  logic       is_stype_q, is_stype_d, wr_en_q, wr_en_d;
  logic [2:0] dm_select_q, dm_select_d, imm_select_q, imm_select_d;
  logic [1:0] sel_data_q, sel_data_d, store_select_q, store_select_d;
  logic       is_muldiv_q, is_muldiv_d;
  logic [2:0] muldiv_op_q, muldiv_op_d;
  logic       illegal_q, illegal_d;

  assign busy     = (cnt_q != '0);
  assign in_ready = !busy;
  assign accept   = in_valid & in_ready & !flush;

  always_comb begin
    alu_f3 = 4'd1;
    case (funct3)
      3'd0: alu_f3 = 4'd1;
      3'd1: alu_f3 = 4'd8;
      3'd2: alu_f3 = 4'd6;
      3'd3: alu_f3 = 4'd7;
      3'd4: alu_f3 = 4'd5;
      3'd5: alu_f3 = (funct7 == 7'h20) ? 4'hA : 4'd9;
      3'd6: alu_f3 = 4'd4;
      3'd7: alu_f3 = 4'd3;
      default: alu_f3 = 4'd1;
    endcase
  end

  always_comb begin
    dec_alu_op       = 4'd1;
    dec_sel_opa      = 1'b1;
    dec_sel_opb      = 1'b1;
    dec_is_stype     = 1'b0;
    dec_wr_en        = 1'b1;
    dec_dm_select    = funct3;
    dec_imm_select   = 3'd0;
    dec_sel_data     = 2'd1;
    dec_store_select = 2'd2;
    dec_is_muldiv    = 1'b0;
    dec_muldiv_op    = 3'd0;
    dec_illegal      = 1'b0;
    case (opcode)
      7'h37: begin dec_imm_select = 3'd2; dec_sel_data = 2'd2; end
      7'h17: begin dec_imm_select = 3'd2; dec_sel_opa = 1'b0; end
      7'h6F: begin dec_imm_select = 3'd4; dec_sel_data = 2'd0; dec_sel_opa = 1'b0; end
      7'h67: begin dec_imm_select = 3'd4; dec_sel_data = 2'd0; end
      7'h63: begin
        dec_alu_op = 4'd2; dec_imm_select = 3'd3; dec_sel_opb = 1'b0; dec_wr_en = 1'b0;
      end
      7'h03: dec_sel_data = 2'd3;
      7'h23: begin
        dec_is_stype   = 1'b1;
        dec_wr_en      = 1'b0;
        dec_imm_select = 3'd1;
        dec_store_select = (funct3 == 3'd0) ? 2'd0 : (funct3 == 3'd1) ? 2'd1 : 2'd2;
      end
      7'h13: dec_alu_op = alu_f3;
      7'h33: begin
        dec_sel_opb = 1'b0;
        if (funct7 == 7'h01) begin
          if (EN_M != 0) begin
            dec_is_muldiv = 1'b1;
            dec_muldiv_op = funct3;
          end else begin
            dec_illegal = 1'b1;
          end
        end else begin
          dec_alu_op = (funct3 == 3'd0 && funct7 == 7'h20) ? 4'd2 : alu_f3;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    // An illegal word carries no control side effects, only the flag.
    if (dec_illegal) begin
      dec_alu_op       = 4'd0;
      dec_sel_opa      = 1'b0;
      dec_sel_opb      = 1'b0;
      dec_is_stype     = 1'b0;
      dec_wr_en        = 1'b0;
      dec_dm_select    = 3'd0;
      dec_imm_select   = 3'd0;
      dec_sel_data     = 2'd0;
      dec_store_select = 2'd0;
      dec_is_muldiv    = 1'b0;
      dec_muldiv_op    = 3'd0;
    end
  end

  always_comb begin
    out_valid_d    = 1'b0;
    alu_op_d       = 4'd0;
    sel_opa_d      = 1'b0;
    sel_opb_d      = 1'b0;
    is_stype_d     = 1'b0;
    wr_en_d        = 1'b0;
    dm_select_d    = 3'd0;
    imm_select_d   = 3'd0;
    sel_data_d     = 2'd0;
    store_select_d = 2'd0;
    is_muldiv_d    = 1'b0;
    muldiv_op_d    = 3'd0;
    illegal_d      = 1'b0;
    if (accept) begin
      out_valid_d    = 1'b1;
      alu_op_d       = dec_alu_op;
      sel_opa_d      = dec_sel_opa;
      sel_opb_d      = dec_sel_opb;
      is_stype_d     = dec_is_stype;
      wr_en_d        = dec_wr_en;
      dm_select_d    = dec_dm_select;
      imm_select_d   = dec_imm_select;
      sel_data_d     = dec_sel_data;
      store_select_d = dec_store_select;
      is_muldiv_d    = dec_is_muldiv;
      muldiv_op_d    = dec_muldiv_op;
      illegal_d      = dec_illegal;
    end
  end

  // A zero load value means a single-cycle op, which never raises busy.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept && dec_is_muldiv) begin
      cnt_d = funct3[2] ? DIV_LOAD : MUL_LOAD;
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      out_valid_q    <= 1'b0;
      alu_op_q       <= 4'd0;
      sel_opa_q      <= 1'b0;
      sel_opb_q      <= 1'b0;
      is_stype_q     <= 1'b0;
      wr_en_q        <= 1'b0;
      dm_select_q    <= 3'd0;
      imm_select_q   <= 3'd0;
      sel_data_q     <= 2'd0;
      store_select_q <= 2'd0;
      is_muldiv_q    <= 1'b0;
      muldiv_op_q    <= 3'd0;
      illegal_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      out_valid_q    <= out_valid_d;
      alu_op_q       <= alu_op_d;
      sel_opa_q      <= sel_opa_d;
      sel_opb_q      <= sel_opb_d;
      is_stype_q     <= is_stype_d;
      wr_en_q        <= wr_en_d;
      dm_select_q    <= dm_select_d;
      imm_select_q   <= imm_select_d;
      sel_data_q     <= sel_data_d;
      store_select_q <= store_select_d;
      is_muldiv_q    <= is_muldiv_d;
      muldiv_op_q    <= muldiv_op_d;
      illegal_q      <= illegal_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign ALU_op       = alu_op_q;
  assign sel_opA      = sel_opa_q;
  assign sel_opB      = sel_opb_q;
  assign is_stype     = is_stype_q;
  assign wr_en        = wr_en_q;
  assign dm_select    = dm_select_q;
  assign imm_select   = imm_select_q;
  assign sel_data     = sel_data_q;
  assign store_select = store_select_q;
  assign is_muldiv    = is_muldiv_q;
  assign muldiv_op    = muldiv_op_q;
  assign muldiv_start = out_valid_q & is_muldiv_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_id_ctrl_seq.sv
// Directed bench for id_ctrl_seq: default build, a MUL_LAT=1 build and an EN_M=0 build
// all see the same instruction stream.
module tb_id_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       flush;

  logic       in_ready, out_valid, sel_opa, sel_opb, is_stype, wr_en, is_muldiv, muldiv_start, illegal;
  logic [3:0] alu_op;
  logic [2:0] dm_select, imm_select, muldiv_op;
  logic [1:0] sel_data, store_select;

  logic       m1_in_ready, m1_out_valid, m1_sel_opa, m1_sel_opb, m1_is_stype, m1_wr_en;
  logic       m1_is_muldiv, m1_muldiv_start, m1_illegal;
  logic [3:0] m1_alu_op;
  logic [2:0] m1_dm_select, m1_imm_select, m1_muldiv_op;
  logic [1:0] m1_sel_data, m1_store_select;

  logic       nm_in_ready, nm_out_valid, nm_sel_opa, nm_sel_opb, nm_is_stype, nm_wr_en;
  logic       nm_is_muldiv, nm_muldiv_start, nm_illegal;
  logic [3:0] nm_alu_op;
  logic [2:0] nm_dm_select, nm_imm_select, nm_muldiv_op;
  logic [1:0] nm_sel_data, nm_store_select;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ctrl_seq #(.EN_M(1), .MUL_LAT(2), .DIV_LAT(33), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
    .ALU_op(alu_op), .sel_opA(sel_opa), .sel_opB(sel_opb), .is_stype(is_stype),
    .wr_en(wr_en), .dm_select(dm_select), .imm_select(imm_select), .sel_data(sel_data),
    .store_select(store_select), .is_muldiv(is_muldiv), .muldiv_op(muldiv_op),
    .muldiv_start(muldiv_start), .illegal(illegal));

  id_ctrl_seq #(.EN_M(1), .MUL_LAT(1), .DIV_LAT(33), .CNT_W(6)) dut_m1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .flush(flush), .in_ready(m1_in_ready), .out_valid(m1_out_valid),
    .ALU_op(m1_alu_op), .sel_opA(m1_sel_opa), .sel_opB(m1_sel_opb), .is_stype(m1_is_stype),
    .wr_en(m1_wr_en), .dm_select(m1_dm_select), .imm_select(m1_imm_select),
    .sel_data(m1_sel_data), .store_select(m1_store_select), .is_muldiv(m1_is_muldiv),
    .muldiv_op(m1_muldiv_op), .muldiv_start(m1_muldiv_start), .illegal(m1_illegal));

  id_ctrl_seq #(.EN_M(0), .MUL_LAT(2), .DIV_LAT(33), .CNT_W(6)) dut_nm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .flush(flush), .in_ready(nm_in_ready), .out_valid(nm_out_valid),
    .ALU_op(nm_alu_op), .sel_opA(nm_sel_opa), .sel_opB(nm_sel_opb), .is_stype(nm_is_stype),
    .wr_en(nm_wr_en), .dm_select(nm_dm_select), .imm_select(nm_imm_select),
    .sel_data(nm_sel_data), .store_select(nm_store_select), .is_muldiv(nm_is_muldiv),
    .muldiv_op(nm_muldiv_op), .muldiv_start(nm_muldiv_start), .illegal(nm_illegal));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic fl);
    in_valid = v;
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
    flush    = fl;
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int stalls;
    int starts;

    rst = 1'b1;
    applyStimulus(1'b1, 7'h33, 3'd0, 7'h00, 1'b0);
    tick();
    tick();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_alu_op", alu_op, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_sel_data", sel_data, 0);
    checkOutput("rst_store_select", store_select, 0);
    checkOutput("rst_sel_opb", sel_opb, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 7'h00, 3'd0, 7'h00, 1'b0);
    tick();
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("idle_out_valid", out_valid, 0);

    applyStimulus(1'b1, 7'h33, 3'd0, 7'h00, 1'b0);
    tick();
    checkOutput("add_out_valid", out_valid, 1);
    checkOutput("add_alu_op", alu_op, 1);
    checkOutput("add_wr_en", wr_en, 1);
    checkOutput("add_sel_opb", sel_opb, 0);
    applyStimulus(1'b1, 7'h33, 3'd0, 7'h20, 1'b0);
    tick();
    checkOutput("sub_alu_op", alu_op, 2);
    applyStimulus(1'b1, 7'h13, 3'd5, 7'h20, 1'b0);
    tick();
    checkOutput("srai_alu_op", alu_op, 4'hA);
    checkOutput("srai_sel_opb", sel_opb, 1);
    applyStimulus(1'b1, 7'h23, 3'd2, 7'h00, 1'b0);
    tick();
    checkOutput("sw_alu_op", alu_op, 1);
    checkOutput("sw_is_stype", is_stype, 1);
    checkOutput("sw_store_select", store_select, 2);
    checkOutput("sw_wr_en", wr_en, 0);
    checkOutput("sw_imm_select", imm_select, 1);
    applyStimulus(1'b1, 7'h63, 3'd0, 7'h00, 1'b0);
    tick();
    checkOutput("beq_alu_op", alu_op, 2);
    checkOutput("beq_imm_select", imm_select, 3);
    checkOutput("beq_wr_en", wr_en, 0);
    checkOutput("beq_out_valid", out_valid, 1);
    applyStimulus(1'b1, 7'h37, 3'd0, 7'h00, 1'b0);
    tick();
    checkOutput("lui_sel_data", sel_data, 2);
    checkOutput("lui_imm_select", imm_select, 2);
    applyStimulus(1'b1, 7'h6F, 3'd0, 7'h00, 1'b0);
    tick();
    checkOutput("jal_sel_data", sel_data, 0);
    checkOutput("jal_sel_opa", sel_opa, 0);
    checkOutput("jal_imm_select", imm_select, 4);
    applyStimulus(1'b1, 7'h03, 3'd4, 7'h00, 1'b0);
    tick();
    checkOutput("lbu_sel_data", sel_data, 3);
    checkOutput("lbu_dm_select", dm_select, 4);
    applyStimulus(1'b1, 7'h23, 3'd0, 7'h00, 1'b0);
    tick();
    checkOutput("sb_store_select", store_select, 0);
    applyStimulus(1'b1, 7'h13, 3'd7, 7'h00, 1'b0);
    tick();
    checkOutput("andi_alu_op", alu_op, 3);
    applyStimulus(1'b0, 7'h33, 3'd0, 7'h00, 1'b0);
    tick();
    checkOutput("bubble_out_valid", out_valid, 0);
    checkOutput("bubble_wr_en", wr_en, 0);

    // DIV then ADD held valid
    applyStimulus(1'b1, 7'h33, 3'd4, 7'h01, 1'b0);
    tick();
    checkOutput("div_muldiv_start", muldiv_start, 1);
    checkOutput("div_muldiv_op", muldiv_op, 4);
    checkOutput("div_is_muldiv", is_muldiv, 1);
    checkOutput("div_wr_en", wr_en, 1);
    checkOutput("div_alu_op", alu_op, 1);
    checkOutput("div_sel_opb", sel_opb, 0);
    checkOutput("div_in_ready", in_ready, 0);
    checkOutput("nm_div_out_valid", nm_out_valid, 1);
    checkOutput("nm_div_illegal", nm_illegal, 1);
    checkOutput("nm_div_wr_en", nm_wr_en, 0);
    checkOutput("nm_div_is_muldiv", nm_is_muldiv, 0);
    checkOutput("nm_div_in_ready", nm_in_ready, 1);
    applyStimulus(1'b1, 7'h33, 3'd0, 7'h00, 1'b0);
    n = 0; stalls = 0; starts = 0;
    while (n < 40) begin
      if (!in_ready) stalls++;
      tick();
      n++;
      if (muldiv_start) starts++;
      if (out_valid) break;
    end
    checkOutput("div_accept_distance", n, 33);
    checkOutput("div_stall_cycles", stalls, 32);
    checkOutput("div_extra_starts", starts, 0);
    checkOutput("div_add_out_valid", out_valid, 1);
    checkOutput("div_add_is_muldiv", is_muldiv, 0);

    // MUL: MUL_LAT=2 stalls one cycle, MUL_LAT=1 none
    applyStimulus(1'b1, 7'h33, 3'd0, 7'h01, 1'b0);
    tick();
    checkOutput("mul_muldiv_start", muldiv_start, 1);
    checkOutput("mul_muldiv_op", muldiv_op, 0);
    checkOutput("mul_in_ready", in_ready, 0);
    checkOutput("m1_mul_muldiv_start", m1_muldiv_start, 1);
    checkOutput("m1_mul_in_ready", m1_in_ready, 1);
    applyStimulus(1'b1, 7'h33, 3'd0, 7'h00, 1'b0);
    tick();
    checkOutput("mul_stall_out_valid", out_valid, 0);
    checkOutput("mul_stall_start", muldiv_start, 0);
    checkOutput("mul_ready_again", in_ready, 1);
    checkOutput("m1_add_out_valid", m1_out_valid, 1);
    checkOutput("m1_add_is_muldiv", m1_is_muldiv, 0);
    tick();
    checkOutput("mul_add_out_valid", out_valid, 1);
    checkOutput("mul_add_is_muldiv", is_muldiv, 0);

    // Flush during the fifth stall cycle of a DIV
    applyStimulus(1'b1, 7'h33, 3'd5, 7'h01, 1'b0);
    tick();
    checkOutput("divu_muldiv_start", muldiv_start, 1);
    applyStimulus(1'b0, 7'h00, 3'd0, 7'h00, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("flush_pre_in_ready", in_ready, 0);
    applyStimulus(1'b1, 7'h33, 3'd0, 7'h00, 1'b1);
    tick();
    checkOutput("flush_stall_in_ready", in_ready, 1);
    checkOutput("flush_stall_out_valid", out_valid, 0);
    applyStimulus(1'b0, 7'h00, 3'd0, 7'h00, 1'b0);
    starts = 0; stalls = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (muldiv_start) starts++;
      if (!in_ready) stalls++;
    end
    checkOutput("flush_no_start", starts, 0);
    checkOutput("flush_no_stall", stalls, 0);

    // Flush together with in_valid drops the instruction
    applyStimulus(1'b1, 7'h33, 3'd0, 7'h20, 1'b1);
    tick();
    checkOutput("flush_drop_out_valid", out_valid, 0);
    checkOutput("flush_drop_alu_op", alu_op, 0);
    // Flush in the out_valid cycle leaves that cycle intact
    applyStimulus(1'b1, 7'h33, 3'd0, 7'h20, 1'b0);
    tick();
    applyStimulus(1'b1, 7'h33, 3'd0, 7'h00, 1'b1);
    #1;
    checkOutput("flush_hold_out_valid", out_valid, 1);
    checkOutput("flush_hold_alu_op", alu_op, 2);
    tick();
    checkOutput("flush_next_out_valid", out_valid, 0);

    // Illegal opcode
    applyStimulus(1'b1, 7'h7F, 3'd0, 7'h00, 1'b0);
    tick();
    checkOutput("ill_out_valid", out_valid, 1);
    checkOutput("ill_illegal", illegal, 1);
    checkOutput("ill_wr_en", wr_en, 0);
    checkOutput("ill_is_stype", is_stype, 0);
    checkOutput("ill_is_muldiv", is_muldiv, 0);
    checkOutput("ill_in_ready", in_ready, 1);

    // Reset in the middle of a stall
    applyStimulus(1'b1, 7'h33, 3'd6, 7'h01, 1'b0);
    tick();
    applyStimulus(1'b0, 7'h00, 3'd0, 7'h00, 1'b0);
    tick();
    checkOutput("rst_mid_pre_in_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_in_ready", in_ready, 1);
    checkOutput("rst_mid_out_valid", out_valid, 0);
    rst = 1'b0;
    applyStimulus(1'b1, 7'h13, 3'd6, 7'h00, 1'b0);
    tick();
    checkOutput("rst_mid_ori_alu_op", alu_op, 4);
    checkOutput("rst_mid_ori_out_valid", out_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
